// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg: shared types and constants for the uio pad-group arbiter.
//   arb_state_e : arbiter FSM states (IDLE / OWN / TURN)
//   UIO_W       : pad group width
//   OE_DRIVE / OE_FLOAT : the only two legal pad-enable patterns
//   MAX_NREQ / IDX_W    : largest supported requester count and the index
//                         width that covers it (requester vectors are padded
//                         to MAX_NREQ so a fixed-width index is always exact)
//   rr_next()   : wrap-around increment of a requester index
package uio_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_TURN} arb_state_e;

  localparam int               UIO_W    = 8;
  localparam logic [UIO_W-1:0] OE_DRIVE = 8'hFF;
  localparam logic [UIO_W-1:0] OE_FLOAT = 8'h00;
  localparam int               MAX_NREQ = 4;
  localparam int               IDX_W    = $clog2(MAX_NREQ);

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_pick.sv
// uio_rr_pick: combinational round-robin picker.
//   i_req [NREQ]  : request vector
//   i_ptr [IDX_W] : index holding highest priority this pass
//   o_gnt [NREQ]  : one-hot winner (zero when no request)
//   o_idx [IDX_W] : winner index
//   o_any         : at least one request present
module uio_rr_pick
  import uio_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [MAX_NREQ-1:0] w_req_pad;
  logic [IDX_W:0]      w_j;

  assign w_req_pad = MAX_NREQ'(i_req);

  // Scan i_ptr, i_ptr+1, ... modulo NREQ; first asserted request wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_j >= (IDX_W+1)'(NREQ)) w_j = w_j - (IDX_W+1)'(NREQ);
      if (!o_any && w_req_pad[w_j[IDX_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_j[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < NREQ; i++) o_gnt[i] = o_any && (o_idx == IDX_W'(i));
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the shared 8-bit uio pad group.
// Grants one requester at a time, drives uio_out/uio_oe for a writing owner,
// samples uio_in for a reading owner, and holds the pads floating for
// TURN_CYC cycles after a driving owner lets go.
//   clk, rst_n (async, active low), ena (gates new grants only)
//   req/dir/wdata : per-requester request, direction (1=drive), write byte
//   gnt/preempt   : registered one-hot grant, timeout-revoke pulse
//   rdata/rvalid  : registered uio_in sample for a reading owner
//   busy          : FSM not idle
//   uio_in/uio_out/uio_oe : pad group (outputs registered)
// Optional: define UIO_ARB_TIMEOUT_EN to force release after MAX_HOLD OWN
// cycles with a preempt pulse; otherwise preempt is 0 and grants hold.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       dir,
  input  logic [NREQ*UIO_W-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       preempt,
  output logic [UIO_W-1:0]      rdata,
  output logic                  rvalid,
  output logic                  busy,
  input  logic [UIO_W-1:0]      uio_in,
  output logic [UIO_W-1:0]      uio_out,
  output logic [UIO_W-1:0]      uio_oe
);

  if (NREQ < 2 || NREQ > MAX_NREQ || TURN_CYC < 1 || TURN_CYC > 3 || MAX_HOLD < 1) begin : g_bad_param
    $error("uio_bus_arbiter: parameter out of range");
  end

  arb_state_e              r_state, w_state_n;
  logic [IDX_W-1:0]        r_owner, w_owner_n;
  logic                    r_own_dir, w_dir_n;
  // r_ptr holds the index with highest priority on the next IDLE pass, i.e.
  // last granted + 1. Reset 0 so requester 0 is favoured first.
  logic [IDX_W-1:0]        r_ptr, w_ptr_n;
  logic [NREQ-1:0]         r_gnt, w_gnt_n;
  logic [UIO_W-1:0]        r_rdata, w_rdata_n;
  logic                    r_rvalid, w_rvalid_n;
  logic [UIO_W-1:0]        r_uio_out, w_out_n;
  logic [UIO_W-1:0]        r_uio_oe, w_oe_n;
  logic [1:0]              r_turn, w_turn_n;
  logic                    w_rel;

  logic [MAX_NREQ-1:0]             w_req_pad, w_dir_pad;
  logic [MAX_NREQ-1:0][UIO_W-1:0]  w_wdata_pad;
  logic [NREQ-1:0]                 w_pick;
  logic [IDX_W-1:0]                w_pick_idx;
  logic                            w_any;

  assign w_req_pad   = MAX_NREQ'(req);
  assign w_dir_pad   = MAX_NREQ'(dir);
  assign w_wdata_pad = (MAX_NREQ*UIO_W)'(wdata);

  uio_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick),
    .o_idx (w_pick_idx),
    .o_any (w_any)
  );

`ifdef UIO_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] r_hold, w_hold_n;
  logic [NREQ-1:0]   r_preempt, w_pre_n;
  logic              w_to;
`endif

  always_comb begin
    w_state_n  = r_state;
    w_owner_n  = r_owner;
    w_dir_n    = r_own_dir;
    w_ptr_n    = r_ptr;
    w_gnt_n    = r_gnt;
    w_rdata_n  = r_rdata;
    w_rvalid_n = r_rvalid;
    w_out_n    = r_uio_out;
    w_oe_n     = r_uio_oe;
    w_turn_n   = r_turn;
    w_rel      = 1'b0;
`ifdef UIO_ARB_TIMEOUT_EN
    w_hold_n   = r_hold;
    w_pre_n    = '0;
    w_to       = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_gnt_n    = '0;
        w_oe_n     = OE_FLOAT;
        w_out_n    = '0;
        w_rvalid_n = 1'b0;
        if (ena && w_any) begin
          // Grant and pad direction are registered on the same edge.
          w_state_n = ST_OWN;
          w_owner_n = w_pick_idx;
          w_dir_n   = w_dir_pad[w_pick_idx];
          w_ptr_n   = rr_next(w_pick_idx, NREQ);
          w_gnt_n   = w_pick;
          if (w_dir_pad[w_pick_idx]) begin
            w_oe_n  = OE_DRIVE;
            w_out_n = w_wdata_pad[w_pick_idx];
          end
`ifdef UIO_ARB_TIMEOUT_EN
          w_hold_n = '0;
`endif
        end
      end
      ST_OWN: begin
        w_rel = !w_req_pad[r_owner];
`ifdef UIO_ARB_TIMEOUT_EN
        w_hold_n = r_hold + 1'b1;
        w_to     = !w_rel && (r_hold == HOLD_W'(MAX_HOLD - 1));
        if (w_to) w_pre_n = r_gnt;
        if (w_rel || w_to) begin
`else
        if (w_rel) begin
`endif
          // Pads float on the same edge the grant drops.
          w_gnt_n    = '0;
          w_oe_n     = OE_FLOAT;
          w_out_n    = '0;
          w_rvalid_n = 1'b0;
          w_turn_n   = '0;
          w_state_n  = r_own_dir ? ST_TURN : ST_IDLE;
        end else if (r_own_dir) begin
          w_oe_n  = OE_DRIVE;
          w_out_n = w_wdata_pad[r_owner];
        end else begin
          w_rdata_n  = uio_in;
          w_rvalid_n = 1'b1;
        end
      end
      ST_TURN: begin
        if (r_turn == 2'(TURN_CYC - 1)) w_state_n = ST_IDLE;
        else                            w_turn_n  = r_turn + 1'b1;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_own_dir <= 1'b0;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_uio_out <= '0;
      r_uio_oe  <= OE_FLOAT;
      r_turn    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_owner   <= w_owner_n;
      r_own_dir <= w_dir_n;
      r_ptr     <= w_ptr_n;
      r_gnt     <= w_gnt_n;
      r_rdata   <= w_rdata_n;
      r_rvalid  <= w_rvalid_n;
      r_uio_out <= w_out_n;
      r_uio_oe  <= w_oe_n;
      r_turn    <= w_turn_n;
    end
  end

`ifdef UIO_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_preempt <= '0;
    end else begin
      r_hold    <= w_hold_n;
      r_preempt <= w_pre_n;
    end
  end
  assign preempt = r_preempt;
`else
  assign preempt = '0;
`endif

  assign gnt     = r_gnt;
  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;
  assign busy    = (r_state != ST_IDLE);
  assign uio_out = r_uio_out;
  assign uio_oe  = r_uio_oe;

endmodule
